// File: rtl/xor_stream_parity_mux_if.sv
// Frame stream in, registered frame result out; both directions use valid/ready.
// Producer/consumer side uses master, the accumulator block uses slave.
interface xor_stream_parity_mux_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xor;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, odd_mode, out_ready,
    input  in_ready, out_valid, out_xor, out_parity, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, odd_mode, out_ready,
    output in_ready, out_valid, out_xor, out_parity, out_count, out_ovf
  );
endinterface

// File: rtl/xor_stream_parity_mux.sv
// Per-frame XOR/parity/beat-count accumulator built from 2:1 mux cells; result one cycle after last beat.
// One-entry output register; input stalls (in_ready=0) while a result waits on out_ready.
module xor_stream_parity_mux_mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module xor_stream_parity_mux #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  xor_stream_parity_mux_if.slave io
);
  logic [WIDTH-1:0] acc, acc_inv, acc_n;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             ovf_flag, cnt_max;
  logic [WIDTH:0]   par;
  logic [WIDTH-1:0] par_inv;

  logic             out_valid_q, out_parity_q, out_ovf_q;
  logic [WIDTH-1:0] out_xor_q;
  logic [CNT_W-1:0] out_count_q;

  logic in_fire, out_fire;

  assign io.in_ready = !out_valid_q | io.out_ready;
  assign in_fire     = io.in_valid & io.in_ready;
  assign out_fire    = out_valid_q & io.out_ready;

  // acc XOR data: data bit selects acc or its mux-built inverse.
  // Parity ripples through the same cell pattern, seeded with odd_mode.
  assign par[0] = io.odd_mode;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      xor_stream_parity_mux_mux2 u_acc_not (
        .sel(acc[i]), .d0(1'b1), .d1(1'b0), .y(acc_inv[i])
      );
      xor_stream_parity_mux_mux2 u_acc_xor (
        .sel(io.in_data[i]), .d0(acc[i]), .d1(acc_inv[i]), .y(acc_n[i])
      );
      xor_stream_parity_mux_mux2 u_par_not (
        .sel(par[i]), .d0(1'b1), .d1(1'b0), .y(par_inv[i])
      );
      xor_stream_parity_mux_mux2 u_par_xor (
        .sel(acc_n[i]), .d0(par[i]), .d1(par_inv[i]), .y(par[i+1])
      );
    end
  endgenerate

  assign cnt_max = (cnt == {CNT_W{1'b1}});
  assign cnt_inc = cnt_max ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      ovf_flag     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_xor_q    <= '0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      if (in_fire) begin
        if (io.in_last) begin
          // Loading a new result overrides the drain above, keeping one result per cycle.
          out_valid_q  <= 1'b1;
          out_xor_q    <= acc_n;
          out_parity_q <= par[WIDTH];
          out_count_q  <= cnt_inc;
          out_ovf_q    <= ovf_flag | cnt_max;
          acc          <= '0;
          cnt          <= '0;
          ovf_flag     <= 1'b0;
        end else begin
          acc      <= acc_n;
          cnt      <= cnt_inc;
          ovf_flag <= ovf_flag | cnt_max;
        end
      end
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.out_xor    = out_xor_q;
  assign io.out_parity = out_parity_q;
  assign io.out_count  = out_count_q;
  assign io.out_ovf    = out_ovf_q;
endmodule

// File: tb/tb_xor_stream_parity_mux.sv
// Directed frames with hand-computed results; a queue scoreboard checks each accepted output.
module tb_xor_stream_parity_mux;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic             p;
    logic [CNT_W-1:0] c;
    logic             o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  xor_stream_parity_mux_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  xor_stream_parity_mux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: a result is consumed on the edge after valid&ready is seen.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(bus.out_xor), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_xor",    32'(bus.out_xor),    32'(e.x));
        chk("out_parity", 32'(bus.out_parity), 32'(e.p));
        chk("out_count",  32'(bus.out_count),  32'(e.c));
        chk("out_ovf",    32'(bus.out_ovf),    32'(e.o));
      end
    end
  end

  task automatic expect_res(input logic [WIDTH-1:0] x, input logic p,
                            input logic [CNT_W-1:0] c, input logic o);
    exp_t e;
    e.x = x; e.p = p; e.c = c; e.o = o;
    exp_q.push_back(e);
  endtask

  // Drive one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic last, input logic mode);
    bit ok;
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.odd_mode = mode;
    guard = 0;
    ok = 1'b0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) chk("send_timeout", 32'(guard), 32'd0);
    if (ok && last) chk("result_latency", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.odd_mode  = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst_out_xor",    32'(bus.out_xor),    32'd0);
    chk("rst_out_count",  32'(bus.out_count),  32'd0);
    chk("rst_out_parity", 32'(bus.out_parity), 32'd0);
    chk("rst_out_ovf",    32'(bus.out_ovf),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Multi-beat frame, even parity
    send(8'h0F, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    expect_res(8'hFE, 1'b1, 8'd3, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    idle();
    @(posedge clk);
    #1;
    chk("out_valid_drops", 32'(bus.out_valid), 32'd0);

    // Single beat, odd then even mode
    expect_res(8'hFF, 1'b1, 8'd1, 1'b0);
    send(8'hFF, 1'b1, 1'b1);
    expect_res(8'hFF, 1'b0, 8'd1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    idle();
    drain();

    // Backpressure: A held, B stalled behind it
    bus.out_ready = 1'b0;
    expect_res(8'h3C, 1'b0, 8'd1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    bus.in_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_xor",   32'(bus.out_xor),   32'h3C);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'h01, 1'b0, 1'b0);
    expect_res(8'h03, 1'b0, 8'd2, 1'b0);
    send(8'h02, 1'b1, 1'b0);
    idle();
    drain();

    // Back-to-back single-beat frames
    expect_res(8'h01, 1'b1, 8'd1, 1'b0);
    expect_res(8'h03, 1'b0, 8'd1, 1'b0);
    expect_res(8'h07, 1'b1, 8'd1, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    chk("b2b_in_ready0", 32'(bus.in_ready), 32'd1);
    send(8'h03, 1'b1, 1'b0);
    chk("b2b_in_ready1", 32'(bus.in_ready), 32'd1);
    send(8'h07, 1'b1, 1'b0);
    chk("b2b_in_ready2", 32'(bus.in_ready), 32'd1);
    idle();
    drain();

    // Count saturation and overflow flag
    for (int k = 0; k < 300; k++) send(8'hAA, 1'b0, 1'b0);
    expect_res(8'h00, 1'b0, 8'd255, 1'b1);
    send(8'h00, 1'b1, 1'b0);
    expect_res(8'h5A, 1'b0, 8'd1, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    idle();
    drain();

    // Reset mid-frame discards the partial frame
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_xor",   32'(bus.out_xor),   32'd0);
    chk("midrst_out_count", 32'(bus.out_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_res(8'h44, 1'b0, 8'd1, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    idle();
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
